sparse_operand_issuer: RTL
==========================

Name: sparse_operand_issuer

Overview:
- Transmit side of the MFU operand interface in the sparse DNN datapath.
- Consumes two compressed sparse streams (nonzero value + index): activations and weights.
- Performs an index-intersection merge and issues only matching (a, w) pairs as 9-bit sign/zero-extended operands to the MFU, 8x8 mode.
- Ends every vector with a zero-operand terminator beat that carries the count of issued pairs.

Parameters:
- IDX_W, 8, width of element index within a vector
- CNT_W, 9, width of per-vector issued-pair counter (saturating)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- a_signed  in  1  activation extension mode (1 = sign-extend, 0 = zero-extend); quasi-static, changed only between vectors
- w_signed  in  1  weight extension mode, same rules
- act_valid  in  1  activation head valid
- act_ready  out  1  activation pop
- act_data  in  8  activation value
- act_idx  in  IDX_W  activation index
- act_last  in  1  final activation element of vector
- wgt_valid  in  1  weight head valid
- wgt_ready  out  1  weight pop
- wgt_data  in  8  weight value
- wgt_idx  in  IDX_W  weight index
- wgt_last  in  1  final weight element of vector
- out_valid  out  1  operand beat valid
- out_ready  in  1  MFU side accepts beat
- out_a  out  9  extended activation operand
- out_w  out  9  extended weight operand
- out_idx  out  IDX_W  matched index
- out_last  out  1  terminator beat
- out_cnt  out  CNT_W  pairs issued this vector; meaningful only when out_last = 1

Behaviour:
- Handshakes: a transfer occurs on valid & ready in the same cycle. Output is a single registered slot, with slot_free = !out_valid | out_ready. The slot holds all fields stable while out_valid & !out_ready.
- Reset: out_valid = 0, out_a = 0, out_w = 0, out_idx = 0, out_last = 0, out_cnt = 0, internal count = 0, state = MERGE. act_ready and wgt_ready are 0 during rst.
- Each vector holds at least one element per stream. Indices are strictly increasing within a vector; any violation is undefined.
- MERGE state: compares only when act_valid & wgt_valid. Otherwise both readies are 0.
  - act_idx == wgt_idx and slot_free: pop both; load slot with ext(act_data), ext(wgt_data), idx, out_last = 0; count += 1, saturating at 2^CNT_W-1.
  - act_idx < wgt_idx: pop activation only, with no output; slot state is irrelevant.
  - wgt_idx < act_idx: pop weight only, with no output.
  - Next state after any pop: both popped lasts -> FLUSH; only act last popped -> DRAIN_W; only wgt last popped -> DRAIN_A; otherwise MERGE.
- DRAIN_W: wgt_ready = 1. Discards weights until the element with wgt_last pops, then goes to FLUSH. act_ready = 0. DRAIN_A is symmetric.
- FLUSH: when slot_free, load the terminator beat: out_a = 0, out_w = 0, out_idx = 0, out_last = 1, out_cnt = count. Clear count and go to MERGE. The MFU multiplies 0*0, which is harmless to the accumulator.
- Readies may depend combinationally on input valid, index and last. They never depend on out_valid except through slot_free.
- Latency: a matched pair appears at the output on the cycle after its input pop.
- Throughput: 1 input comparison per cycle; the terminator costs 1 extra output beat per vector.
- Extension: out_a = {a_signed & act_data[7], act_data}; out_w uses the same rule with w_signed.
- rst asserted mid-vector: drops any pending beat and clears count. Upstream FIFOs are reset by the same rst.

Optional Feature:
- Macro ZERO_SKIP_EN.
- Defined: a matched pair where act_data == 0 or wgt_data == 0 is popped but not issued and not counted. State transitions are identical to an issued match, and the pair does not wait for slot_free.
- Undefined: explicit zero values are issued and counted like any other match.

Test Plan:
- Full intersection: act idx {1,3,5} data {2,-3,4}, wgt idx {0,3,5,7} data {9,5,-2,1}, both signed, out_ready = 1 -> expected beats, in order:
  - (a = 9'h1FD, w = 5, idx 3)
  - (a = 4, w = 9'h1FE, idx 5)
  - terminator with out_cnt = 2 (weight idx 7 discarded in DRAIN_W).
- Disjoint: act idx {2}, wgt idx {1,4} -> only the terminator, out_cnt = 0. Both streams fully consumed, with the last weight consumed in DRAIN_W.
- Backpressure: matches at idx 0,1,2 with out_ready low for 3 cycles after the first beat -> out fields stable while stalled. No pops while the slot is full on a match. Sequence is 0,1,2 then terminator with cnt = 3.
- Unsigned extension: a_signed = 0, act_data = 8'hFF, w_signed = 1, wgt_data = 8'h80, same idx -> out_a = 9'h0FF, out_w = 9'h180.
- Reset mid-vector: rst pulsed one cycle after the first matched beat loads -> next cycle out_valid = 0. A new vector then yields correct cnt starting from 0.
- ZERO_SKIP_EN: matches at idx 2 (act_data = 0) and 6 (both nonzero) -> with the macro, one pair plus cnt = 1. Without the macro, two pairs plus cnt = 2.

Source files
------------

// File: rtl/sparse_operand_issuer.sv
`default_nettype none
// ============================================================================
// Module   : sparse_operand_issuer
// Purpose  : Transmit side of the MFU operand interface for the sparse DNN
//            datapath. Merges two compressed sparse streams (activations and
//            weights, each value + index) by index intersection and issues
//            only the matching pairs as 9-bit sign/zero-extended operands
//            (8x8 mode). Every vector ends with a zero-operand terminator
//            beat that carries the number of pairs issued for that vector.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            a_signed, w_signed  - per-stream extension mode (1 = signed)
//            act_* / wgt_*       - compressed input streams (valid/ready,
//                                  data, idx, last)
//            out_*               - registered operand slot to the MFU
//                                  (valid/ready, a, w, idx, last, cnt)
// Options  : ZERO_SKIP_EN - when defined, matched pairs with a zero operand
//                           are consumed but neither issued nor counted.
// Revision : 1.0 - initial release
// ============================================================================
module sparse_operand_issuer #(
    parameter int IDX_W = 8,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_signed,
    input  logic             w_signed,
    input  logic             act_valid,
    output logic             act_ready,
    input  logic [7:0]       act_data,
    input  logic [IDX_W-1:0] act_idx,
    input  logic             act_last,
    input  logic             wgt_valid,
    output logic             wgt_ready,
    input  logic [7:0]       wgt_data,
    input  logic [IDX_W-1:0] wgt_idx,
    input  logic             wgt_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_a,
    output logic [8:0]       out_w,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [CNT_W-1:0] out_cnt
);

    localparam logic [1:0] c_ST_MERGE   = 2'd0;
    localparam logic [1:0] c_ST_DRAIN_W = 2'd1;
    localparam logic [1:0] c_ST_DRAIN_A = 2'd2;
    localparam logic [1:0] c_ST_FLUSH   = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;

    logic             r_out_valid;
    logic [8:0]       r_out_a;
    logic [8:0]       r_out_w;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_last;
    logic [CNT_W-1:0] r_out_cnt;

    logic             w_slot_free;
    logic             w_zero_pair;
    logic             w_act_rdy;
    logic             w_wgt_rdy;
    logic             w_act_end;
    logic             w_wgt_end;
    logic             w_load_pair;
    logic             w_load_term;
    logic [8:0]       w_ext_a;
    logic [8:0]       w_ext_w;

    // The slot can accept a new beat when it is empty or being drained now.
    assign w_slot_free = !r_out_valid || out_ready;

    assign w_ext_a = {a_signed & act_data[7], act_data};
    assign w_ext_w = {w_signed & wgt_data[7], wgt_data};

`ifdef ZERO_SKIP_EN
    // A product with a zero operand contributes nothing, so the pair is
    // consumed without occupying the output slot.
    assign w_zero_pair = (act_data == 8'd0) || (wgt_data == 8'd0);
`else
    assign w_zero_pair = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state, pop and load decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_act_rdy   = 1'b0;
        w_wgt_rdy   = 1'b0;
        w_act_end   = 1'b0;
        w_wgt_end   = 1'b0;
        w_load_pair = 1'b0;
        w_load_term = 1'b0;
        w_state_nxt = r_state;

        case (r_state)
            c_ST_MERGE: begin
                if (act_valid && wgt_valid) begin
                    if (act_idx == wgt_idx) begin
                        if (w_zero_pair) begin
                            w_act_rdy = 1'b1;
                            w_wgt_rdy = 1'b1;
                        end else if (w_slot_free) begin
                            w_act_rdy   = 1'b1;
                            w_wgt_rdy   = 1'b1;
                            w_load_pair = 1'b1;
                        end
                    end else if (act_idx < wgt_idx) begin
                        // Activation has no partner in the weight stream.
                        w_act_rdy = 1'b1;
                    end else begin
                        w_wgt_rdy = 1'b1;
                    end

                    w_act_end = w_act_rdy && act_last;
                    w_wgt_end = w_wgt_rdy && wgt_last;

                    if (w_act_end && w_wgt_end) begin
                        w_state_nxt = c_ST_FLUSH;
                    end else if (w_act_end) begin
                        w_state_nxt = c_ST_DRAIN_W;
                    end else if (w_wgt_end) begin
                        w_state_nxt = c_ST_DRAIN_A;
                    end
                end
            end

            c_ST_DRAIN_W: begin
                // Remaining weights cannot match anything; discard them.
                w_wgt_rdy = 1'b1;
                if (wgt_valid && wgt_last) begin
                    w_state_nxt = c_ST_FLUSH;
                end
            end

            c_ST_DRAIN_A: begin
                w_act_rdy = 1'b1;
                if (act_valid && act_last) begin
                    w_state_nxt = c_ST_FLUSH;
                end
            end

            c_ST_FLUSH: begin
                if (w_slot_free) begin
                    w_load_term = 1'b1;
                    w_state_nxt = c_ST_MERGE;
                end
            end

            default: begin
                w_state_nxt = c_ST_MERGE;
            end
        endcase

        // Upstream FIFOs share this reset, so nothing may be popped during it.
        if (rst) begin
            w_act_rdy   = 1'b0;
            w_wgt_rdy   = 1'b0;
            w_load_pair = 1'b0;
            w_load_term = 1'b0;
        end
    end

    assign act_ready = w_act_rdy;
    assign wgt_ready = w_wgt_rdy;

    // ------------------------------------------------------------------
    // State register and per-vector pair counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_MERGE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_term) begin
                r_count <= '0;
            end else if (w_load_pair && !(&r_count)) begin
                r_count <= r_count + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output slot: holds all fields while out_valid && !out_ready
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_w     <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_cnt   <= '0;
        end else if (w_load_pair) begin
            r_out_valid <= 1'b1;
            r_out_a     <= w_ext_a;
            r_out_w     <= w_ext_w;
            r_out_idx   <= act_idx;
            r_out_last  <= 1'b0;
        end else if (w_load_term) begin
            // Zero operands make the terminator a harmless 0*0 at the MFU.
            r_out_valid <= 1'b1;
            r_out_a     <= '0;
            r_out_w     <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b1;
            r_out_cnt   <= r_count;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_w     = r_out_w;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign out_cnt   = r_out_cnt;

endmodule
`default_nettype wire
